// File: rtl/bip_pkg.sv
// Shared encodings for the BIP control unit: opcodes, accumulator-source selects,
// run-FSM states and the decoded control bundle.
package bip_pkg;

  localparam logic [4:0] OP_HLT  = 5'b00000;
  localparam logic [4:0] OP_STO  = 5'b00001;
  localparam logic [4:0] OP_LD   = 5'b00010;
  localparam logic [4:0] OP_LDI  = 5'b00011;
  localparam logic [4:0] OP_ADD  = 5'b00100;
  localparam logic [4:0] OP_ADDI = 5'b00101;
  localparam logic [4:0] OP_SUB  = 5'b00110;
  localparam logic [4:0] OP_SUBI = 5'b00111;

  localparam logic [1:0] SELA_RAM = 2'b00;
  localparam logic [1:0] SELA_IMM = 2'b01;
  localparam logic [1:0] SELA_ALU = 2'b10;

  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_RUN  = 2'd1,
    ST_HALT = 2'd2
  } state_t;

  typedef struct packed {
    logic [1:0] sel_a;
    logic       sel_b;
    logic       wr_acc;
    logic       wr_ram;
    logic       rd_ram;
    logic       illegal;
    logic       halt;
  } dec_t;

endpackage

// File: rtl/bip_decoder.sv
// Opcode decoder: pure combinational map from opcode to datapath controls.
// Zero latency; no flow control.
module bip_decoder
  import bip_pkg::*;
#(
  parameter int NB_OPCODE = 5
) (
  input  logic [NB_OPCODE-1:0] opcode,
  output dec_t                 dec
);

  always_comb begin
    dec = '0;
    case (opcode)
      NB_OPCODE'(OP_HLT):  dec.halt = 1'b1;
      NB_OPCODE'(OP_STO):  dec.wr_ram = 1'b1;
      NB_OPCODE'(OP_LD): begin
        dec.rd_ram = 1'b1;
        dec.sel_a  = SELA_RAM;
        dec.wr_acc = 1'b1;
      end
      NB_OPCODE'(OP_LDI): begin
        dec.sel_a  = SELA_IMM;
        dec.wr_acc = 1'b1;
      end
      NB_OPCODE'(OP_ADD), NB_OPCODE'(OP_SUB): begin
        dec.rd_ram = 1'b1;
        dec.sel_a  = SELA_ALU;
        dec.sel_b  = 1'b0;
        dec.wr_acc = 1'b1;
      end
      NB_OPCODE'(OP_ADDI), NB_OPCODE'(OP_SUBI): begin
        dec.sel_a  = SELA_ALU;
        dec.sel_b  = 1'b1;
        dec.wr_acc = 1'b1;
      end
      // Undefined opcodes run as a NOP but are flagged.
      default: dec.illegal = 1'b1;
    endcase
  end

endmodule

// File: rtl/bip_control.sv
// BIP control unit: PC, run FSM, executed-instruction counter and decode gating.
// One instruction per cycle; controls are combinational from i_instr, state commits on the edge.
module bip_control
  import bip_pkg::*;
#(
  parameter int NB_PC            = 11,
  parameter int NB_OPCODE        = 5,
  parameter int NB_OPERANDO      = 11,
  parameter int NB_INSTR         = 16,
  parameter int NB_DECODER_SEL_A = 2,
  parameter int NB_CYC           = 16
) (
  input  logic                        i_clk,
  input  logic                        i_rst,
  input  logic                        i_start,
  input  logic [NB_INSTR-1:0]         i_instr,
  output logic [NB_PC-1:0]            o_pc,
  output logic [NB_OPERANDO-1:0]      o_operando,
  output logic [NB_OPCODE-1:0]        o_op,
  output logic [NB_DECODER_SEL_A-1:0] o_selA,
  output logic                        o_selB,
  output logic                        o_wrAcc,
  output logic                        o_wr_ram,
  output logic                        o_rd_ram,
  output logic                        o_halted,
  output logic                        o_illegal,
  output logic [NB_CYC-1:0]           o_cycles
);

  localparam logic [NB_PC-1:0]  PC_ONE  = NB_PC'(1);
  localparam logic [NB_CYC-1:0] CYC_ONE = NB_CYC'(1);

  state_t                state;
  logic [NB_PC-1:0]      pc;
  logic [NB_CYC-1:0]     cycles;
  logic                  halted;
  logic                  illegal;
  logic                  run;
  logic [NB_OPCODE-1:0]  opcode;
  dec_t                  dec;

  assign opcode = i_instr[NB_INSTR-1 -: NB_OPCODE];
  assign run    = (state == ST_RUN);

  bip_decoder #(
    .NB_OPCODE (NB_OPCODE)
  ) u_dec (
    .opcode (opcode),
    .dec    (dec)
  );

  // Outside RUN every control output is forced low so memory stays untouched.
  always_comb begin
    o_op       = '0;
    o_operando = '0;
    o_selA     = '0;
    o_selB     = 1'b0;
    o_wrAcc    = 1'b0;
    o_wr_ram   = 1'b0;
    o_rd_ram   = 1'b0;
    if (run) begin
      o_op       = opcode;
      o_operando = i_instr[NB_OPERANDO-1:0];
      o_selA     = NB_DECODER_SEL_A'(dec.sel_a);
      o_selB     = dec.sel_b;
      o_wrAcc    = dec.wr_acc;
      o_wr_ram   = dec.wr_ram;
      o_rd_ram   = dec.rd_ram;
    end
  end

  always_ff @(posedge i_clk) begin
    if (!i_rst) begin
      state   <= ST_IDLE;
      pc      <= '0;
      cycles  <= '0;
      halted  <= 1'b0;
      illegal <= 1'b0;
    end else begin
      case (state)
        ST_IDLE: begin
          if (i_start) state <= ST_RUN;
        end
        ST_RUN: begin
          if (cycles != '1) cycles <= cycles + CYC_ONE;
          if (dec.illegal)  illegal <= 1'b1;
          // HLT parks the PC on its own address.
          if (dec.halt) begin
            state  <= ST_HALT;
            halted <= 1'b1;
          end else begin
            pc <= pc + PC_ONE;
          end
        end
        ST_HALT: state <= ST_HALT;
        default: state <= ST_IDLE;
      endcase
    end
  end

  assign o_pc      = pc;
  assign o_cycles  = cycles;
  assign o_halted  = halted;
  assign o_illegal = illegal;

endmodule
